ring_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 21 ++
 rtl/ring_fifo_mem.sv | 35 +++
 rtl/ring_fifo.sv | 151 +++++++++++++++
 tb/tb_ring_fifo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and sizing helpers, reused by ring_fifo and the UART wrappers.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ring_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port and one registered read port.
module ring_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // write port; contents are intentionally not reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // read register; a same-edge write to rd_addr returns the old word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO: pointer-based storage, fill level, almost flags,
// synchronous flush and sticky overflow/underflow.
module ring_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int ALMOST_FULL  = DEPTH - 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          write_enable,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          read_enable,
    output logic [WIDTH-1:0]              data_out,
    output logic                          data_valid,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int LW = level_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(ALMOST_FULL);
    localparam logic [LW-1:0] AE_LVL   = LW'(ALMOST_EMPTY);

    localparam fifo_status_t STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    logic [PW-1:0] wr_ptr_r, wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_r, rd_ptr_nxt_s;
    logic [LW-1:0] level_r, level_nxt_s;
    fifo_status_t  status_r, status_nxt_s;
    logic          data_valid_r, data_valid_nxt_s;
    logic          push_ok_s, pop_ok_s, mem_wr_s, mem_rd_s;

    // wrap by explicit compare so non-power-of-two depths work
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return '0;
        end else begin
            return ptr + PTR_ONE;
        end
    endfunction

    // acceptance: a pop frees a slot, so a push at full succeeds alongside it
    always_comb begin
        pop_ok_s  = read_enable && !status_r.empty;
        push_ok_s = write_enable && (!status_r.full || pop_ok_s);
        mem_wr_s  = push_ok_s && !clear;
        mem_rd_s  = pop_ok_s && !clear;
    end

    // next-state for pointers, level, data_valid and status; clear wins over requests
    always_comb begin
        wr_ptr_nxt_s     = wr_ptr_r;
        rd_ptr_nxt_s     = rd_ptr_r;
        level_nxt_s      = level_r;
        data_valid_nxt_s = 1'b0;
        status_nxt_s     = status_r;
        if (clear) begin
            wr_ptr_nxt_s           = '0;
            rd_ptr_nxt_s           = '0;
            level_nxt_s            = '0;
            status_nxt_s.overflow  = 1'b0;
            status_nxt_s.underflow = 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_nxt_s = level_r + LVL_ONE;
                2'b01:   level_nxt_s = level_r - LVL_ONE;
                default: level_nxt_s = level_r;
            endcase
            data_valid_nxt_s       = pop_ok_s;
            status_nxt_s.overflow  = status_r.overflow  | (write_enable & ~push_ok_s);
            status_nxt_s.underflow = status_r.underflow | (read_enable  & ~pop_ok_s);
        end
        status_nxt_s.full         = (level_nxt_s == LVL_FULL);
        status_nxt_s.empty        = (level_nxt_s == '0);
        status_nxt_s.almost_full  = (level_nxt_s >= AF_LVL);
        status_nxt_s.almost_empty = (level_nxt_s <= AE_LVL);
    end

    // control state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            data_valid_r <= 1'b0;
            status_r     <= STATUS_RST;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            level_r      <= level_nxt_s;
            data_valid_r <= data_valid_nxt_s;
            status_r     <= status_nxt_s;
        end
    end

    ring_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (mem_wr_s),
        .wr_addr (wr_ptr_r),
        .wr_data (data_in),
        .rd_en   (mem_rd_s),
        .rd_addr (rd_ptr_r),
        .rd_data (data_out)
    );

    assign data_valid   = data_valid_r;
    assign level        = level_r;
    assign full         = status_r.full;
    assign empty        = status_r.empty;
    assign almost_full  = status_r.almost_full;
    assign almost_empty = status_r.almost_empty;
    assign overflow     = status_r.overflow;
    assign underflow    = status_r.underflow;

endmodule

// File: tb/tb_ring_fifo.sv
// Bench for ring_fifo (WIDTH=8, DEPTH=5, ALMOST_FULL=4, ALMOST_EMPTY=1) against a queue-based model.
module tb_ring_fifo;

    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       write_enable = 1'b0;
    logic       read_enable = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] level;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_dv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

    localparam logic [17:0] RST_VEC = {8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    ring_fifo #(.WIDTH(8), .DEPTH(D), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .write_enable(write_enable), .data_in(data_in), .read_enable(read_enable),
        .data_out(data_out), .data_valid(data_valid), .level(level),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    function automatic logic [17:0] obs_vec();
        return {data_out, data_valid, level, full, empty, almost_full, almost_empty, overflow, underflow};
    endfunction

    function automatic logic [17:0] model_vec();
        int n;
        n = q.size();
        return {m_dout, m_dv, 3'(n), (n == D), (n == 0), (n >= AF), (n <= AE), m_ovf, m_udf};
    endfunction

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    // drive one cycle, advance the model, return #1 after the edge
    task automatic step(input logic we, input logic [7:0] din, input logic re, input logic clr);
        bit pop_ok, push_ok;
        @(negedge clock);
        write_enable = we; data_in = din; read_enable = re; clear = clr;
        if (clr) begin
            q.delete();
            m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            pop_ok  = re && (q.size() > 0);
            push_ok = we && ((q.size() < D) || pop_ok);
            if (pop_ok) begin
                m_dout = q.pop_front();
                m_dv = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            if (push_ok) q.push_back(din);
            if (we && !push_ok) m_ovf = 1'b1;
            if (re && !pop_ok) m_udf = 1'b1;
        end
        @(posedge clock);
        #1;
        write_enable = 1'b0; read_enable = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++;
        if (obs_vec() !== RST_VEC) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), RST_VEC);
        end
    endtask

    task automatic test_fill_overflow();
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 8'(k), 1'b0, 1'b0);
            vectors++;
            if ({level, data_valid} !== {3'(k), 1'b0}) begin
                miscompares++;
                $display("FAIL fill_level[%0d]: got %0d/%b want %0d/0", k, level, data_valid, k);
            end
        end
        step(1'b1, 8'h06, 1'b0, 1'b0);
        vectors++;
        if ({full, level, overflow} !== {1'b1, 3'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow_push: got full=%b level=%0d ovf=%b want 1/5/1", full, level, overflow);
        end
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if ({data_valid, data_out} !== {1'b1, 8'(k)}) begin
                miscompares++;
                $display("FAIL drain[%0d]: got dv=%b %h want dv=1 %h", k, data_valid, data_out, 8'(k));
            end
        end
        vectors++;
        if ({empty, level} !== {1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL drained_empty: got empty=%b level=%0d want 1/0", empty, level);
        end
    endtask

    task automatic test_full_push_pop();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        vectors++;
        if ({data_valid, data_out, level, overflow} !== {1'b1, 8'h01, 3'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL full_both: got dv=%b %h lvl=%0d ovf=%b want 1 01 5 0", data_valid, data_out, level, overflow);
        end
        for (int k = 0; k < 5; k++) begin
            logic [7:0] want;
            want = (k == 4) ? 8'hAA : 8'(k + 2);
            step(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if ({data_valid, data_out} !== {1'b1, want}) begin
                miscompares++;
                $display("FAIL full_both_drain[%0d]: got %h want %h", k, data_out, want);
            end
        end
    endtask

    task automatic test_empty_push_pop();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        vectors++;
        if ({underflow, data_valid, level} !== {1'b1, 1'b0, 3'd1}) begin
            miscompares++;
            $display("FAIL empty_both: got udf=%b dv=%b lvl=%0d want 1 0 1", underflow, data_valid, level);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if ({data_valid, data_out} !== {1'b1, 8'h33}) begin
            miscompares++;
            $display("FAIL empty_both_next: got dv=%b %h want 1 33", data_valid, data_out);
        end
    endtask

    task automatic test_almost_flags();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step(1'b1, 8'($urandom), 1'b0, 1'b0);
            vectors++;
            if ({almost_empty, almost_full} !== {(k <= AE), (k >= AF)}) begin
                miscompares++;
                $display("FAIL almost[%0d]: got ae=%b af=%b want %b %b", k, almost_empty, almost_full, (k <= AE), (k >= AF));
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0] held;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b1, 8'h98, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        held = m_dout;
        vectors++;
        if ({level, overflow} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_clear: got lvl=%0d ovf=%b want 3 1", level, overflow);
        end
        step(1'b1, 8'h5A, 1'b1, 1'b1);
        vectors++;
        if ({level, empty, overflow, underflow, data_valid, data_out} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, held}) begin
            miscompares++;
            $display("FAIL clear: got lvl=%0d e=%b o=%b u=%b dv=%b %h want 0 1 0 0 0 %h",
                     level, empty, overflow, underflow, data_valid, data_out, held);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step((i % 5) != 4, 8'($urandom), (i % 7) != 3, 1'b0);
            vectors++;
            if (obs_vec() !== model_vec() || level > 3'd5) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got %h want %h", i, obs_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 39) == 0);
            vectors++;
            if (obs_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), model_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (obs_vec() !== RST_VEC) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", obs_vec(), RST_VEC);
        end
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if ({data_valid, data_out, empty} !== {1'b1, 8'h77, 1'b1}) begin
            miscompares++;
            $display("FAIL post_reset_op: got dv=%b %h e=%b want 1 77 1", data_valid, data_out, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_almost_flags();
        test_clear();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
